// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment encodings and FSM state type shared by the seven-segment encoder and decoder
package seven_segment_pkg;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // Indexed by digit value, so SEG_CODES[d] is the pattern that displays d.
  localparam logic [6:0] SEG_CODES [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };
  typedef enum logic {S_WAIT, S_LOCKED} state_t;
endpackage

// File: rtl/seven_segment_lookup.sv
// seven_segment_lookup: combinational map from a segment pattern to {hit, digit}
module seven_segment_lookup
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] digit
);
  always_comb begin
    hit = 1'b0;
    digit = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODES[i]) begin
        hit = 1'b1;
        digit = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: debounces seven segment lines and recovers the hex digit they display
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  logic [6:0] sample, cap;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
  logic same, accept, hit;
  logic [3:0] digit;
  assign sample = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D, i_Segment_E, i_Segment_F, i_Segment_G};
  assign same = sample == cap;
  // Acceptance looks only at registered state, so a new pattern arriving on the
  // accepting edge still lets the held one through (one digit per cycle at STABLE_CYCLES=1).
  assign accept = state == S_WAIT && cnt == CNT_MAX;
  always_comb begin
    cnt_n = !same ? CW'(1) : cnt == CNT_MAX ? cnt : cnt + 1'b1;
    state_n = !same ? S_WAIT : accept ? S_LOCKED : state;
  end
  seven_segment_lookup u_lookup (
    .pattern(cap),
    .hit(hit),
    .digit(digit)
  );
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cap <= SEG_BLANK;
      cnt <= '0;
      state <= S_WAIT;
      o_Binary_Num <= 4'h0;
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      o_Blank <= 1'b0;
    end else begin
      cap <= sample;
      cnt <= cnt_n;
      state <= state_n;
      o_Valid <= accept && hit;
      if (accept) begin
        o_Error <= !hit && cap != SEG_BLANK;
        o_Blank <= cap == SEG_BLANK;
        if (hit) o_Binary_Num <= digit;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: directed vectors for the default decoder plus a STABLE_CYCLES=1 instance
module tb_seven_segment_decoder;
  typedef struct {
    logic [6:0] pattern;
    logic [3:0] digit;
  } vec_t;
  vec_t vecs [16];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg = 7'h00;
  logic [3:0] num, num1;
  logic valid, err, blank, valid1, err1, blank1;
  int vectors = 0;
  int miscompares = 0;
  int pulses, first;
  always #5 clk = ~clk;
  seven_segment_decoder dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Segment_A(seg[6]), .i_Segment_B(seg[5]), .i_Segment_C(seg[4]), .i_Segment_D(seg[3]),
    .i_Segment_E(seg[2]), .i_Segment_F(seg[1]), .i_Segment_G(seg[0]),
    .o_Binary_Num(num), .o_Valid(valid), .o_Error(err), .o_Blank(blank)
  );
  seven_segment_decoder #(.STABLE_CYCLES(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst),
    .i_Segment_A(seg[6]), .i_Segment_B(seg[5]), .i_Segment_C(seg[4]), .i_Segment_D(seg[3]),
    .i_Segment_E(seg[2]), .i_Segment_F(seg[1]), .i_Segment_G(seg[0]),
    .o_Binary_Num(num1), .o_Valid(valid1), .o_Error(err1), .o_Blank(blank1)
  );
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  // Hold p for n edges; report o_Valid pulses seen and the edge index of the first one.
  task automatic apply(input logic [6:0] p, input int n, output int np, output int fe);
    np = 0;
    fe = 0;
    seg = p;
    for (int e = 1; e <= n; e++) begin
      edge1();
      if (valid) begin
        np++;
        if (fe == 0) fe = e;
      end
    end
  endtask
  initial begin
    vecs[0] = '{7'h7E, 4'h0};  vecs[1] = '{7'h30, 4'h1};
    vecs[2] = '{7'h6D, 4'h2};  vecs[3] = '{7'h79, 4'h3};
    vecs[4] = '{7'h33, 4'h4};  vecs[5] = '{7'h5B, 4'h5};
    vecs[6] = '{7'h5F, 4'h6};  vecs[7] = '{7'h70, 4'h7};
    vecs[8] = '{7'h7F, 4'h8};  vecs[9] = '{7'h7B, 4'h9};
    vecs[10] = '{7'h77, 4'hA}; vecs[11] = '{7'h1F, 4'hB};
    vecs[12] = '{7'h4E, 4'hC}; vecs[13] = '{7'h3D, 4'hD};
    vecs[14] = '{7'h4F, 4'hE}; vecs[15] = '{7'h47, 4'hF};
    repeat (2) edge1();
    chk("reset num", num, 0);
    chk("reset valid", valid, 0);
    chk("reset error", err, 0);
    chk("reset blank", blank, 0);
    rst = 1'b0;
    apply(7'h6D, 6, pulses, first);
    chk("6D pulses", pulses, 1);
    chk("6D pulse edge", first, 5);
    chk("6D num", num, 2);
    chk("6D error", err, 0);
    chk("6D blank", blank, 0);
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].pattern, 6, pulses, first);
      chk($sformatf("sweep %0d pulses", i), pulses, 1);
      chk($sformatf("sweep %0d edge", i), first, 5);
      chk($sformatf("sweep %0d num", i), num, vecs[i].digit);
    end
    apply(7'h7E, 6, pulses, first);
    chk("7E num", num, 0);
    apply(7'h01, 6, pulses, first);
    chk("illegal pulses", pulses, 0);
    chk("illegal error", err, 1);
    chk("illegal blank", blank, 0);
    chk("illegal num held", num, 0);
    apply(7'h00, 6, pulses, first);
    chk("blank pulses", pulses, 0);
    chk("blank blank", blank, 1);
    chk("blank error", err, 0);
    chk("blank num held", num, 0);
    apply(7'h30, 6, pulses, first);
    chk("30 pulses", pulses, 1);
    chk("30 num", num, 1);
    apply(7'h31, 2, pulses, first);
    chk("glitch pulses", pulses, 0);
    chk("glitch error", err, 0);
    apply(7'h30, 6, pulses, first);
    chk("reaccept pulses", pulses, 1);
    chk("reaccept edge", first, 5);
    chk("reaccept num", num, 1);
    apply(7'h7E, 3, pulses, first);
    chk("abort 7E pulses", pulses, 0);
    apply(7'h33, 6, pulses, first);
    chk("abort next pulses", pulses, 1);
    chk("abort next edge", first, 5);
    chk("abort next num", num, 4);
    apply(7'h47, 2, pulses, first);
    rst = 1'b1;
    apply(7'h47, 1, pulses, first);
    chk("midreset num", num, 0);
    chk("midreset valid", valid, 0);
    chk("midreset error", err, 0);
    chk("midreset blank", blank, 0);
    rst = 1'b0;
    apply(7'h47, 6, pulses, first);
    chk("postreset pulses", pulses, 1);
    chk("postreset edge", first, 5);
    chk("postreset num", num, 15);
    seg = vecs[0].pattern;
    edge1();
    for (int i = 1; i <= 16; i++) begin
      seg = vecs[i % 16].pattern;
      edge1();
      chk($sformatf("fast %0d valid", i - 1), valid1, 1);
      chk($sformatf("fast %0d num", i - 1), num1, vecs[i - 1].digit);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
